// File: rtl/seg_scan_controller_if.sv
// Bus between the ALU result side and the four-digit seven-segment scanner.
// The master drives data and load requests; the slave drives the board pins.
interface seg_scan_controller_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lzb_en;
  logic        load;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  modport master (
    output enable, value, dp, lzb_en, load,
    input  load_ack, an, seg, dp_n
  );

  modport slave (
    input  enable, value, dp, lzb_en, load,
    output load_ack, an, seg, dp_n
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Four-digit hex scanner: tick prescaler, dwell/blank FSM and a shadow
// register that commits new data only at frame boundaries.
module seg_scan_controller #(
  parameter int DIV         = 50000,
  parameter int DWELL       = 4,
  parameter int BLANK_TICKS = 1
) (
  input logic                  in_clk,
  input logic                  rst,
  seg_scan_controller_if.slave bus
);
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CMAX = (DWELL > BLANK_TICKS) ? DWELL : BLANK_TICKS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     sh_val_q, sh_val_d, pd_val_q, pd_val_d;
  logic [3:0]      sh_dp_q, sh_dp_d, pd_dp_q, pd_dp_d;
  logic            sh_lzb_q, sh_lzb_d, pd_lzb_q, pd_lzb_d;
  logic            pend_q, pend_d;
  logic            ack_q, ack_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_n_q, dp_n_d;

  logic            tick;
  logic            leave_last;
  logic            commit;
  logic            blanked;
  logic [3:0]      nib;
  logic [15:0]     hi_mask;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  assign tick = (pre_q == PW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    leave_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          pre_d   = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          if (cnt_q == CW'(DWELL - 1)) begin
            cnt_d = '0;
            if (BLANK_TICKS > 0) begin
              state_d = BLANK;
            end else begin
              idx_d      = idx_q + 2'd1;
              leave_last = (idx_q == 2'd3);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BLANK: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          if (cnt_q == CW'(BLANK_TICKS - 1)) begin
            cnt_d      = '0;
            state_d    = DRIVE;
            idx_d      = idx_q + 2'd1;
            leave_last = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      pre_d   = '0;
      cnt_d   = '0;
    end
  end

  // A load in the commit cycle lands in pending after the old data moves on.
  always_comb begin
    commit   = pend_q &&
               ((state_q == IDLE) || (leave_last && bus.enable));
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_lzb_d = sh_lzb_q;
    pd_val_d = pd_val_q;
    pd_dp_d  = pd_dp_q;
    pd_lzb_d = pd_lzb_q;
    pend_d   = pend_q;
    if (commit) begin
      sh_val_d = pd_val_q;
      sh_dp_d  = pd_dp_q;
      sh_lzb_d = pd_lzb_q;
      pend_d   = 1'b0;
    end
    if (bus.load) begin
      pd_val_d = bus.value;
      pd_dp_d  = bus.dp;
      pd_lzb_d = bus.lzb_en;
      pend_d   = 1'b1;
    end
    ack_d = commit;
  end

  assign nib     = sh_val_q[{idx_q, 2'b00} +: 4];
  assign hi_mask = 16'hFFFF << {idx_q, 2'b00};
  assign blanked = sh_lzb_q && (idx_q != 2'd0) &&
                   ((sh_val_q & hi_mask) == 16'h0000);

  always_comb begin
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if ((state_q == DRIVE) && bus.enable && !blanked) begin
      an_d   = ~(4'b0001 << idx_q);
      seg_d  = hex7(nib);
      dp_n_d = ~sh_dp_q[idx_q];
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      pre_q    <= '0;
      cnt_q    <= '0;
      sh_val_q <= 16'h0000;
      sh_dp_q  <= 4'h0;
      sh_lzb_q <= 1'b0;
      pd_val_q <= 16'h0000;
      pd_dp_q  <= 4'h0;
      pd_lzb_q <= 1'b0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      sh_lzb_q <= sh_lzb_d;
      pd_val_q <= pd_val_d;
      pd_dp_q  <= pd_dp_d;
      pd_lzb_q <= pd_lzb_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_n_q   <= dp_n_d;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp_n     = dp_n_q;
  assign bus.load_ack = ack_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a frame-arithmetic model
// predicts every output cycle; a negedge monitor pops and compares.
module tb_seg_scan_controller;
  localparam int DIV   = 4;
  localparam int DWELL = 2;
  localparam int BLNK  = 1;
  localparam int DRV   = DWELL * DIV;
  localparam int SLOT  = (DWELL + BLNK) * DIV;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       ack;
  } exp_t;

  logic in_clk = 1'b0;
  logic rst;
  seg_scan_controller_if bus ();

  seg_scan_controller #(
    .DIV(DIV), .DWELL(DWELL), .BLANK_TICKS(BLNK)
  ) dut (
    .in_clk(in_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 in_clk = ~in_clk;

  logic [6:0] hex_tab [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  bit          m_run;
  int          m_s;
  logic [15:0] m_sv, m_pv;
  logic [3:0]  m_sd, m_pd;
  logic        m_sl, m_pl, m_pend;

  task automatic model_clear();
    m_run = 0; m_s = 0;
    m_sv = 16'h0; m_pv = 16'h0;
    m_sd = 4'h0;  m_pd = 4'h0;
    m_sl = 0; m_pl = 0; m_pend = 0;
  endtask

  // Evaluated at each rising edge with the inputs the DUT samples there.
  task automatic model_edge();
    exp_t e;
    int ph, dig;
    logic [15:0] up;
    bit commit;
    e = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, ack: 1'b0};
    if (rst) begin
      model_clear();
      exp_q.push_back(e);
      return;
    end
    if (m_run && bus.enable) begin
      ph  = m_s % FRAME;
      dig = ph / SLOT;
      up  = m_sv >> (4 * dig);
      if ((ph % SLOT) < DRV && !(m_sl && dig > 0 && up == 16'h0)) begin
        e.an   = 4'hF ^ (4'b0001 << dig);
        e.seg  = hex_tab[up[3:0]];
        e.dp_n = !m_sd[dig];
      end
    end
    commit = m_pend &&
             (!m_run || (bus.enable && (m_s % FRAME) == FRAME - 1));
    e.ack = commit;
    exp_q.push_back(e);
    if (commit) begin
      m_sv = m_pv; m_sd = m_pd; m_sl = m_pl; m_pend = 0;
    end
    if (bus.load) begin
      m_pv = bus.value; m_pd = bus.dp; m_pl = bus.lzb_en; m_pend = 1;
    end
    if (!bus.enable) begin
      m_run = 0; m_s = 0;
    end else if (!m_run) begin
      m_run = 1; m_s = 0;
    end else begin
      m_s++;
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    model_edge();
    #1;
    bus.load = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic l);
    bus.value  = v;
    bus.dp     = d;
    bus.lzb_en = l;
    bus.load   = 1'b1;
    step();
  endtask

  // Advance until the next edge sees frame phase t.
  task automatic align(input int t);
    int n = 0;
    while ((!m_run || (m_s % FRAME) != t) && n < 2 * FRAME) begin
      step();
      n++;
    end
    total++;
    if (n >= 2 * FRAME) begin
      bad++;
      $display("FAIL align phase=%0d got run=%0d s=%0d want reached",
               t, m_run, m_s);
    end
  endtask

  always @(negedge in_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (bus.an !== e.an || bus.seg !== e.seg || bus.dp_n !== e.dp_n) begin
        bad++;
        $display("FAIL disp t=%0t got an=%h seg=%h dp_n=%b want an=%h seg=%h dp_n=%b",
                 $time, bus.an, bus.seg, bus.dp_n, e.an, e.seg, e.dp_n);
      end
      total++;
      if (bus.load_ack !== e.ack) begin
        bad++;
        $display("FAIL ack t=%0t got %b want %b", $time, bus.load_ack, e.ack);
      end
    end
  end

  initial begin
    model_clear();
    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.value  = 16'h0;
    bus.dp     = 4'h0;
    bus.lzb_en = 1'b0;
    bus.load   = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(FRAME + 4);

    bus.enable = 1'b0;
    step();
    do_load(16'h1234, 4'b0100, 1'b0);
    step();
    bus.enable = 1'b1;
    cyc(2 * FRAME);

    align(SLOT + 2);
    do_load(16'h0050, 4'h0, 1'b1);
    cyc(2 * FRAME);
    do_load(16'h0000, 4'h0, 1'b1);
    cyc(2 * FRAME);

    align(SLOT + 3);
    do_load(16'hFFFF, 4'h0, 1'b0);
    cyc(FRAME + 10);

    align(2);
    do_load(16'hAAAA, 4'h0, 1'b0);
    cyc(5);
    do_load(16'hBBBB, 4'h0, 1'b0);
    cyc(FRAME);

    align(5);
    do_load(16'h1111, 4'hF, 1'b0);
    align(FRAME - 1);
    do_load(16'h2222, 4'h1, 1'b0);
    cyc(2 * FRAME);

    align(2 * SLOT + 3);
    bus.enable = 1'b0;
    cyc(3);
    bus.enable = 1'b1;
    cyc(FRAME + 5);

    align(10);
    do_load(16'hABCD, 4'h3, 1'b0);
    cyc(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc(FRAME + 5);

    for (int i = 0; i < 1500; i++) begin
      bus.enable = ($urandom_range(0, 49) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) begin
        bus.value  = ($urandom_range(0, 3) == 0) ?
                     16'($urandom_range(0, 255)) : 16'($urandom);
        bus.dp     = 4'($urandom);
        bus.lzb_en = 1'($urandom);
        bus.load   = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    cyc(FRAME);

    @(negedge in_clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
